if_fetch_controller: RTL and testbench

- Sequences the instruction memory: owns the program counter and drives the fetch address.
- Captures the fetched word into the IF/ID pipeline register each cycle.
- Handles hazard freeze, branch redirect/flush, and halts when the PC runs past the last populated memory word.
- Sits between the hazard/branch logic and the combinational instruction memory.

---
 rtl/if_fetch_controller.sv | 118 +++++++++++
 tb/tb_if_fetch_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_controller.sv
// if_fetch_controller: owns the program counter, drives the instruction
// memory address and captures the fetched word into the IF/ID register.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   freeze       in   hazard stall; holds PC and IF/ID
//   branch_taken in   redirect request from the branch unit
//   branch_adrs  in   redirect target (byte address, low bits ignored)
//   imem_adrs    out  fetch address (combinational copy of PC)
//   imem_inst    in   word returned combinationally by instruction memory
//   if_id_pc     out  PC+4 of the captured instruction
//   if_id_inst   out  captured instruction
//   if_id_valid  out  IF/ID holds a real fetched instruction
//   halted       out  controller is in HALT
//   fetch_count  out  saturating count of captures since reset
module if_fetch_controller #(
    parameter int unsigned             ADDR_W   = 32,
    parameter int unsigned             INST_W   = 32,
    parameter logic [ADDR_W-1:0]       PC_RESET = '0,
    parameter logic [ADDR_W-1:0]       MEM_LAST = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_adrs,
    output logic [ADDR_W-1:0] imem_adrs,
    input  logic [INST_W-1:0] imem_inst,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [INST_W-1:0] if_id_inst,
    output logic              if_id_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ifpc_q, ifpc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;

    // Redirect targets are forced word-aligned.
    assign target = branch_adrs & ~ADDR_W'(3);
    // Wraps modulo 2^ADDR_W.
    assign pc_inc = pc_q + ADDR_W'(4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifpc_d  = ifpc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (state_q == S_HALT) begin
            // IF/ID is already flushed; freeze has no effect here.
            if (branch_taken) begin
                pc_d    = target;
                state_d = S_RUN;
            end
        end else if (branch_taken) begin
            // Branch wins over freeze and flushes IF/ID.
            pc_d    = target;
            ifpc_d  = '0;
            inst_d  = '0;
            valid_d = 1'b0;
        end else if (!freeze) begin
            if (pc_q > MEM_LAST) begin
                state_d = S_HALT;
                ifpc_d  = '0;
                inst_d  = '0;
                valid_d = 1'b0;
            end else begin
                // Only edge on which imem_inst is sampled.
                pc_d    = pc_inc;
                ifpc_d  = pc_inc;
                inst_d  = imem_inst;
                valid_d = 1'b1;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= PC_RESET;
            ifpc_q  <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifpc_q  <= ifpc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_adrs   = pc_q;
    assign if_id_pc    = ifpc_q;
    assign if_id_inst  = inst_q;
    assign if_id_valid = valid_q;
    assign halted      = (state_q == S_HALT);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_controller.sv
// Bench for if_fetch_controller: three instances with different MEM_LAST
// share stimulus and are checked against a behavioural model every cycle.
module tb_if_fetch_controller;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_adrs = '0;

    logic [31:0] imem_adrs [ND];
    logic [31:0] imem_inst [ND];
    logic [31:0] if_id_pc [ND];
    logic [31:0] if_id_inst [ND];
    logic        if_id_valid [ND];
    logic        halted [ND];
    logic [15:0] fetch_count [ND];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00000000;
            32'h4:   return 32'h8001060A;
            32'h8:   return 32'h04011000;
            default: return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] mlast(input int k);
        case (k)
            0:       return 32'd100;
            1:       return 32'd24;
            default: return 32'hFFFFFFFC;
        endcase
    endfunction

    for (genvar g = 0; g < ND; g++) begin : gd
        assign imem_inst[g] = mem(imem_adrs[g]);
        if_fetch_controller #(
            .ADDR_W(32), .INST_W(32),
            .PC_RESET(32'h0), .MEM_LAST(mlast(g))
        ) dut (
            .clk(clk), .rst(rst), .freeze(freeze),
            .branch_taken(branch_taken), .branch_adrs(branch_adrs),
            .imem_adrs(imem_adrs[g]), .imem_inst(imem_inst[g]),
            .if_id_pc(if_id_pc[g]), .if_id_inst(if_id_inst[g]),
            .if_id_valid(if_id_valid[g]), .halted(halted[g]),
            .fetch_count(fetch_count[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state per instance.
    logic [31:0] m_pc [ND];
    logic [31:0] m_ifpc [ND];
    logic [31:0] m_inst [ND];
    logic        m_v [ND];
    logic        m_h [ND];
    int          m_cnt [ND];
    bit          m_ok = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (rst) begin
                m_pc[k] = 0; m_ifpc[k] = 0; m_inst[k] = 0;
                m_v[k] = 0; m_h[k] = 0; m_cnt[k] = 0;
            end else if (m_h[k]) begin
                if (branch_taken) begin
                    m_pc[k] = {branch_adrs[31:2], 2'b00};
                    m_h[k] = 0;
                end
            end else if (branch_taken) begin
                m_pc[k] = {branch_adrs[31:2], 2'b00};
                m_ifpc[k] = 0; m_inst[k] = 0; m_v[k] = 0;
            end else if (freeze) begin
            end else if (m_pc[k] > mlast(k)) begin
                m_h[k] = 1; m_ifpc[k] = 0; m_inst[k] = 0; m_v[k] = 0;
            end else begin
                m_inst[k] = mem(m_pc[k]);
                m_pc[k] = m_pc[k] + 32'd4;
                m_ifpc[k] = m_pc[k];
                m_v[k] = 1;
                if (m_cnt[k] < 65535) m_cnt[k]++;
            end
        end
        if (rst) m_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            for (int k = 0; k < ND; k++) begin
                chk($sformatf("d%0d_adrs", k), imem_adrs[k], m_pc[k]);
                chk($sformatf("d%0d_ifpc", k), if_id_pc[k], m_ifpc[k]);
                chk($sformatf("d%0d_inst", k), if_id_inst[k], m_inst[k]);
                chk($sformatf("d%0d_valid", k), 32'(if_id_valid[k]), 32'(m_v[k]));
                chk($sformatf("d%0d_halted", k), 32'(halted[k]), 32'(m_h[k]));
                chk($sformatf("d%0d_cnt", k), 32'(fetch_count[k]), m_cnt[k]);
            end
        end
    end

    initial begin
        // Sequential fetch after a 2-cycle reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_adrs", imem_adrs[0], 32'h0);
        chk("rst_valid", 32'(if_id_valid[0]), 32'h0);
        chk("rst_cnt", 32'(fetch_count[0]), 32'h0);
        chk("rst_halted", 32'(halted[0]), 32'h0);
        @(negedge clk);
        chk("seq1_inst", if_id_inst[0], 32'h00000000);
        chk("seq1_pc", if_id_pc[0], 32'h4);
        chk("seq1_valid", 32'(if_id_valid[0]), 32'h1);
        @(negedge clk);
        chk("seq2_inst", if_id_inst[0], 32'h8001060A);
        chk("seq2_pc", if_id_pc[0], 32'h8);
        chk("seq2_adrs", imem_adrs[0], 32'h8);

        // Freeze for three cycles at address 8.
        freeze = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("frz_adrs", imem_adrs[0], 32'h8);
            chk("frz_inst", if_id_inst[0], 32'h8001060A);
            chk("frz_cnt", 32'(fetch_count[0]), 32'd2);
        end
        freeze = 1'b0;
        @(negedge clk);
        chk("seq3_inst", if_id_inst[0], 32'h04011000);
        chk("seq3_pc", if_id_pc[0], 32'hC);
        chk("seq3_cnt", 32'(fetch_count[0]), 32'd3);

        // Branch together with freeze at pc=12.
        freeze = 1'b1; branch_taken = 1'b1; branch_adrs = 32'h17;
        @(negedge clk);
        freeze = 1'b0; branch_taken = 1'b0;
        chk("br_adrs", imem_adrs[0], 32'h14);
        chk("br_valid", 32'(if_id_valid[0]), 32'h0);
        chk("br_inst", if_id_inst[0], 32'h0);
        chk("br_cnt", 32'(fetch_count[0]), 32'd3);
        @(negedge clk);
        chk("br_cap_inst", if_id_inst[0], 32'hA5D7FFEB);
        chk("br_cap_pc", if_id_pc[0], 32'h18);

        // Halt and resume on the MEM_LAST=24 instance.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        chk("hlt_cnt7", 32'(fetch_count[1]), 32'd7);
        chk("hlt_pc7", if_id_pc[1], 32'd28);
        chk("hlt_v7", 32'(if_id_valid[1]), 32'h1);
        @(negedge clk);
        chk("hlt_h", 32'(halted[1]), 32'h1);
        chk("hlt_v", 32'(if_id_valid[1]), 32'h0);
        for (int i = 0; i < 5; i++) begin
            freeze = i[0];
            @(negedge clk);
            chk("hlt_hold_h", 32'(halted[1]), 32'h1);
            chk("hlt_hold_adrs", imem_adrs[1], 32'd28);
            chk("hlt_hold_v", 32'(if_id_valid[1]), 32'h0);
        end
        freeze = 1'b0; branch_taken = 1'b1; branch_adrs = 32'h4;
        @(negedge clk);
        branch_taken = 1'b0;
        chk("res_h", 32'(halted[1]), 32'h0);
        chk("res_adrs", imem_adrs[1], 32'h4);
        @(negedge clk);
        chk("res_inst", if_id_inst[1], 32'h8001060A);
        chk("res_pc", if_id_pc[1], 32'h8);
        chk("res_cnt", 32'(fetch_count[1]), 32'd8);

        // Reset coincident with a branch at pc=16.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mr_pre_adrs", imem_adrs[0], 32'd16);
        rst = 1'b1; branch_taken = 1'b1; branch_adrs = 32'h40; freeze = 1'b1;
        @(negedge clk);
        rst = 1'b0; branch_taken = 1'b0; freeze = 1'b0;
        chk("mr_adrs", imem_adrs[0], 32'h0);
        chk("mr_inst", if_id_inst[0], 32'h0);
        chk("mr_pc", if_id_pc[0], 32'h0);
        chk("mr_valid", 32'(if_id_valid[0]), 32'h0);
        chk("mr_cnt", 32'(fetch_count[0]), 32'h0);
        chk("mr_halted", 32'(halted[0]), 32'h0);

        // PC wrap on the MEM_LAST=FFFFFFFC instance.
        branch_taken = 1'b1; branch_adrs = 32'hFFFFFFFE;
        @(negedge clk);
        branch_taken = 1'b0;
        chk("wr_adrs", imem_adrs[2], 32'hFFFFFFFC);
        @(negedge clk);
        chk("wr_pc", if_id_pc[2], 32'h0);
        chk("wr_inst", if_id_inst[2], 32'h5A3F0003);
        chk("wr_adrs0", imem_adrs[2], 32'h0);
        @(negedge clk);
        chk("wr_inst0", if_id_inst[2], 32'h00000000);
        chk("wr_pc0", if_id_pc[2], 32'h4);

        // Randomised traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            branch_adrs = ($urandom_range(0, 3) == 0) ? $urandom
                                                      : $urandom_range(0, 140);
            freeze = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
